// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller: validates a request, runs one bus access
// with a bounded wait, and returns an aligned, extended load result.
module mem_access_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memMemRead,
  input  logic        memMemWrite,
  input  logic [2:0]  memMemMode,
  input  logic [31:0] memALUOut,
  input  logic [31:0] memWriteToMemData,
  output logic        stall,
  output logic [31:0] memReadData,
  output logic        accErr,
  output logic        busValid,
  output logic        busWrite,
  output logic [31:0] busAddr,
  output logic [3:0]  busByteEn,
  output logic [31:0] busWData,
  input  logic        busReady,
  input  logic [31:0] busRData
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  logic [1:0]  state;
  logic [7:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [3:0]  be_q;
  logic        write_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;

  logic [1:0]  size;
  logic [1:0]  lane;
  logic        req_any;
  logic        misaligned;
  logic        legal;
  logic        timed_out;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign size       = memMemMode[1:0];
  assign lane       = memALUOut[1:0];
  assign req_any    = memMemRead | memMemWrite;
  assign misaligned = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
  assign legal      = (memMemRead ^ memMemWrite) && (size != 2'b11) && !misaligned;
  assign timed_out  = (state == BUSY) && (cnt == TIMEOUT_CNT);

  // Gated by rst_n so a request presented during reset cannot leak out.
  assign stall    = rst_n && (((state == IDLE) && legal) || (state == BUSY));
  assign accErr   = rst_n && (((state == IDLE) && req_any && !legal) || (timed_out && !busReady));
  assign busValid = (state == BUSY) && !timed_out;

  assign busAddr     = addr_q;
  assign busWrite    = write_q;
  assign busByteEn   = be_q;
  assign busWData    = wdata_q;
  assign memReadData = rdata_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    be_next    = 4'b1111;
    wdata_next = memWriteToMemData;
    case (size)
      2'b00: begin
        be_next    = 4'b0001 << lane;
        wdata_next = {4{memWriteToMemData[7:0]}};
      end
      2'b01: begin
        be_next    = 4'b0011 << lane;
        wdata_next = {2{memWriteToMemData[15:0]}};
      end
      default: ;
    endcase
  end

  // Little-endian extraction from the returned word using the latched lane.
  assign shifted = busRData >> {lane_q, 3'b000};

  always_comb begin
    load_data = busRData;
    case (size_q)
      2'b00: load_data = uns_q ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01: load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      write_q <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (legal) begin
            state   <= BUSY;
            cnt     <= '0;
            addr_q  <= {memALUOut[31:2], 2'b00};
            wdata_q <= wdata_next;
            be_q    <= be_next;
            write_q <= memMemWrite;
            uns_q   <= memMemMode[2];
            size_q  <= size;
            lane_q  <= lane;
          end
        end
        BUSY: begin
          // Completion takes priority over the timeout in the same cycle.
          if (busReady) begin
            if (!write_q) rdata_q <= load_data;
            state <= DONE;
          end else if (timed_out) begin
            rdata_q <= '0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: a transaction-level model predicts the
// per-cycle outputs, a negedge process compares, and directed cases pin literals.
module tb_mem_access_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        memMemRead, memMemWrite;
  logic [2:0]  memMemMode;
  logic [31:0] memALUOut, memWriteToMemData;
  logic        stall, accErr, busValid, busWrite, busReady;
  logic [31:0] memReadData, busAddr, busWData, busRData;
  logic [3:0]  busByteEn;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .memMemRead(memMemRead), .memMemWrite(memMemWrite), .memMemMode(memMemMode),
    .memALUOut(memALUOut), .memWriteToMemData(memWriteToMemData),
    .stall(stall), .memReadData(memReadData), .accErr(accErr),
    .busValid(busValid), .busWrite(busWrite), .busAddr(busAddr),
    .busByteEn(busByteEn), .busWData(busWData),
    .busReady(busReady), .busRData(busRData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        acc;
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mrd = '0;
  int          stall_cnt, valid_cnt, acc_cnt;
  logic [31:0] last_addr, last_wdata;
  logic [3:0]  last_be;
  logic        last_write;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [3:0] be_model(input int lane, input int n);
    logic [3:0] be;
    for (int b = 0; b < 4; b++) be[b] = (b >= lane) && (b < lane + n);
    return be;
  endfunction

  function automatic logic [31:0] wdata_model(input logic [31:0] d, input int n);
    logic [31:0] w;
    for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] load_model(input logic [31:0] w, input int lane,
                                             input int size, input logic uns);
    int nb;
    logic [31:0] v, mask;
    if (size == 2) return w;
    nb   = 1 << size;
    mask = (nb == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v    = (w >> (8 * lane)) & mask;
    if (!uns && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic exp_t quiet_exp();
    exp_t e;
    e = '{stall: 1'b0, acc: 1'b0, valid: 1'b0, write: 1'b0,
          addr: '0, be: '0, wdata: '0, rdata: mrd};
    return e;
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (stall) stall_cnt++;
    if (accErr) acc_cnt++;
    if (busValid) begin
      valid_cnt++;
      last_addr  = busAddr;
      last_be    = busByteEn;
      last_wdata = busWData;
      last_write = busWrite;
    end
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall", 32'(stall), 32'(e.stall));
      check("accErr", 32'(accErr), 32'(e.acc));
      check("busValid", 32'(busValid), 32'(e.valid));
      check("memReadData", memReadData, e.rdata);
      if (e.valid) begin
        check("busWrite", 32'(busWrite), 32'(e.write));
        check("busAddr", busAddr, e.addr);
        check("busByteEn", 32'(busByteEn), 32'(e.be));
        check("busWData", busWData, e.wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive_req(input logic rd, input logic wr, input logic [2:0] mode,
                           input logic [31:0] a, input logic [31:0] d);
    memMemRead        = rd;
    memMemWrite       = wr;
    memMemMode        = mode;
    memALUOut         = a;
    memWriteToMemData = d;
  endtask

  task automatic drive_garbage();
    drive_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              $urandom, $urandom);
  endtask

  task automatic do_idle();
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
    busReady = 1'($urandom_range(0, 1));
    busRData = $urandom;
    exp_q.push_back(quiet_exp());
  endtask

  task automatic do_illegal(input logic rd, input logic wr, input logic [2:0] mode,
                            input logic [31:0] a);
    exp_t e;
    @(posedge clk); #1;
    drive_req(rd, wr, mode, a, $urandom);
    busReady = 1'($urandom_range(0, 1));
    busRData = $urandom;
    e = quiet_exp();
    e.acc = 1'b1;
    exp_q.push_back(e);
  endtask

  // w = BUSY cycle (1-based) in which busReady rises; 0 means never (timeout).
  task automatic do_legal(input logic rd, input logic wr, input logic [2:0] mode,
                          input logic [31:0] a, input logic [31:0] d,
                          input int w, input logic [31:0] rdat);
    exp_t e;
    int lane, size, n;
    size = int'(mode[1:0]);
    lane = int'(a[1:0]);
    n    = 1 << size;
    @(posedge clk); #1;
    drive_req(rd, wr, mode, a, d);
    busReady = 1'b0;
    busRData = $urandom;
    e = quiet_exp();
    e.stall = 1'b1;
    exp_q.push_back(e);
    for (int i = 1; i <= TO + 1; i++) begin
      @(posedge clk); #1;
      drive_garbage();
      busReady = (i == w);
      busRData = (i == w) ? rdat : $urandom;
      e = '{stall: 1'b1, acc: (i == TO + 1) && (w != i), valid: (i <= TO), write: wr,
            addr: a & 32'hFFFF_FFFC, be: be_model(lane, n), wdata: wdata_model(d, n),
            rdata: mrd};
      exp_q.push_back(e);
      if (i == w) break;
    end
    if (w == 0) mrd = '0;
    else if (rd) mrd = load_model(rdat, lane, size, mode[2]);
    @(posedge clk); #1;
    drive_garbage();
    busReady = 1'($urandom_range(0, 1));
    busRData = $urandom;
    exp_q.push_back(quiet_exp());
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stall"}, 32'(stall), 32'd0);
    check({tag, "_accErr"}, 32'(accErr), 32'd0);
    check({tag, "_busValid"}, 32'(busValid), 32'd0);
    check({tag, "_busWrite"}, 32'(busWrite), 32'd0);
    check({tag, "_busByteEn"}, 32'(busByteEn), 32'd0);
    check({tag, "_busAddr"}, busAddr, 32'd0);
    check({tag, "_busWData"}, busWData, 32'd0);
    check({tag, "_memReadData"}, memReadData, 32'd0);
  endtask

  initial begin
    // Reset with an otherwise legal request on the inputs: outputs must stay quiet.
    rst_n    = 1'b0;
    busReady = 1'b0;
    busRData = 32'hDEAD_BEEF;
    drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h1234_5678);
    #12;
    check_zero("reset");
    drive_req(1'b0, 1'b0, 3'b000, '0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Byte load, sign-extended from lane 3.
    stall_cnt = 0;
    do_legal(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 2, 32'h80FF_FF12);
    @(negedge clk); #1;
    check("byte_load_data", memReadData, 32'hFFFF_FF80);
    check("byte_load_addr", last_addr, 32'h0000_1000);
    check("byte_load_be", 32'(last_be), 32'b1000);
    check("byte_load_stall_cycles", stall_cnt, 3);

    // Half store in the upper half: replication, lanes, read data untouched.
    do_legal(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 1, 32'h0);
    @(negedge clk); #1;
    check("half_store_be", 32'(last_be), 32'b1100);
    check("half_store_wdata", last_wdata, 32'hABCD_ABCD);
    check("half_store_write", 32'(last_write), 32'd1);
    check("half_store_keeps_rdata", memReadData, 32'hFFFF_FF80);

    // Misaligned word read.
    valid_cnt = 0;
    do_illegal(1'b1, 1'b0, 3'b010, 32'h0000_3001);
    @(negedge clk); #1;
    check("misaligned_accErr", 32'(accErr), 32'd1);
    check("misaligned_stall", 32'(stall), 32'd0);
    do_idle();
    @(negedge clk); #1;
    check("misaligned_no_bus", valid_cnt, 0);

    // Timeout with busReady held low.
    valid_cnt = 0;
    acc_cnt   = 0;
    do_legal(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 0, 32'h0);
    @(negedge clk); #1;
    check("timeout_valid_cycles", valid_cnt, TO);
    check("timeout_err_pulses", acc_cnt, 1);
    check("timeout_rdata", memReadData, 32'h0);

    // Unsigned half load.
    do_legal(1'b1, 1'b0, 3'b101, 32'h0000_0000, 32'h0, 3, 32'h1234_8001);
    @(negedge clk); #1;
    check("uhalf_load_data", memReadData, 32'h0000_8001);

    // Ready arriving in the timeout cycle completes without error.
    acc_cnt = 0;
    do_legal(1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0, TO + 1, 32'h5555_AAAA);
    @(negedge clk); #1;
    check("late_ready_data", memReadData, 32'h5555_AAAA);
    check("late_ready_no_err", acc_cnt, 0);

    // Reset asserted mid-BUSY.
    begin
      exp_t e;
      @(posedge clk); #1;
      drive_req(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
      busReady = 1'b0;
      e = quiet_exp();
      e.stall = 1'b1;
      exp_q.push_back(e);
      for (int i = 0; i < 2; i++) begin
        @(posedge clk); #1;
        drive_req(1'b0, 1'b0, 3'b000, '0, '0);
        e = '{stall: 1'b1, acc: 1'b0, valid: 1'b1, write: 1'b0, addr: 32'h0000_0200,
              be: 4'b1111, wdata: 32'h0, rdata: mrd};
        exp_q.push_back(e);
      end
      @(posedge clk); #2;
      acc_cnt = 0;
      rst_n   = 1'b0;
      #1;
      check_zero("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      mrd   = '0;
      check("midreset_no_err", acc_cnt, 0);
    end
    do_legal(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 1, 32'hCAFE_F00D);
    @(negedge clk); #1;
    check("post_reset_load", memReadData, 32'hCAFE_F00D);

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      int r, size, w;
      logic rd, wr, legal;
      logic [2:0] mode;
      logic [31:0] a;
      r    = int'($urandom_range(0, 99));
      rd   = (r < 42) || (r >= 84 && r < 92);
      wr   = (r >= 42 && r < 92);
      size = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      mode = {1'($urandom_range(0, 1)), 2'(size)};
      a    = $urandom;
      if (size != 3 && $urandom_range(0, 9) < 7) a = a & ~32'((1 << size) - 1);
      legal = (rd != wr) && (size != 3) && ((a % (1 << size)) == 0);
      if (!rd && !wr) begin
        do_idle();
      end else if (legal) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)      w = 0;
        else if (r == 1) w = TO + 1;
        else             w = int'($urandom_range(1, TO));
        do_legal(rd, wr, mode, a, $urandom, w, $urandom);
      end else begin
        do_illegal(rd, wr, mode, a);
      end
    end
    do_idle();
    @(negedge clk); #1;
    check("expectations_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is asynchronous and active-low.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 memMemRead  input  1  MEM-stage load request.
REQ-005 memMemWrite  input  1  MEM-stage store request.
REQ-006 memMemMode  input  3  access mode: bits[1:0] size (00 byte, 01 half, 10 word, 11 illegal); bit[2] unsigned-load flag.
REQ-007 memALUOut  input  32  byte address.
REQ-008 memWriteToMemData  input  32  store data, right-justified.
REQ-009 stall  output  1  freezes the pipeline while asserted.
REQ-010 memReadData  output  32  aligned, extended load result.
REQ-011 accErr  output  1  one-cycle pulse on an illegal, misaligned or timed-out access.
REQ-012 busValid  output  1  bus request valid.
REQ-013 busWrite  output  1  bus request is a store.
REQ-014 busAddr  output  32  word address: memALUOut with bits[1:0] forced to 00.
REQ-015 busByteEn  output  4  byte lane enables; bit n enables bits[8n+7:8n].
REQ-016 busWData  output  32  lane-replicated store data.
REQ-017 busReady  input  1  bus completes the current request in this cycle.
REQ-018 busRData  input  32  read word, valid when busReady is high.
REQ-019 Parameter TIMEOUT, default 255, maximum number of BUSY cycles to wait for busReady (range 1..255).

Function
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 Legal request: exactly one of memMemRead or memMemWrite is high, size is not 11, and the address is aligned (half: addr[0]=0; word: addr[1:0]=00).
REQ-022 IDLE with no request: stay in IDLE; stall=0.
REQ-023 IDLE with a legal request: stall=1 combinationally in the same cycle; next state BUSY; latch address, mode, lane, write data and direction.
REQ-024 IDLE with an illegal request (read and write both high, size 11, or misaligned): no bus access; accErr=1 for that cycle; stall=0; stay in IDLE.
REQ-025 BUSY outputs: busValid=1, stall=1, and busAddr/busWrite/busByteEn/busWData held from the latched values until the cycle in which busReady=1.
REQ-026 BUSY with busReady=1: capture busRData for a load; next state DONE.
REQ-027 BUSY timeout: a counter clears on entry to BUSY and increments each BUSY cycle without busReady; when it reaches TIMEOUT, drop busValid, pulse accErr, force memReadData=0 and go to DONE.
REQ-028 busReady in the cycle the counter hits TIMEOUT: completion wins; no error.
REQ-029 DONE: stall=0 and memReadData valid for exactly one cycle; next state IDLE unconditionally, so the same instruction is never issued twice.
REQ-030 Byte enables: byte -> 4'b0001 << lane; half -> 4'b0011 << lane; word -> 4'b1111; lane = addr[1:0].
REQ-031 Store data replication: byte -> {4{d[7:0]}}; half -> {2{d[15:0]}}; word -> d.
REQ-032 Load extraction (little-endian): byte = busRData >> (8*lane), low 8 bits; half = low 16 bits after the shift; zero-extend if mode bit[2]=1, otherwise sign-extend; word is passed through.
REQ-033 Store completion: memReadData is unchanged by a store.
REQ-034 busValid SHALL be 0 in IDLE and DONE.
REQ-035 Request inputs SHALL be ignored in BUSY and DONE.

Reset
REQ-036 rst_n=0 forces state=IDLE, timeout counter=0, memReadData=0, all latched request fields=0.
REQ-037 During reset: stall=0, accErr=0, busValid=0, busWrite=0, busByteEn=0, busAddr=0, busWData=0.
REQ-038 Reset asserted mid-BUSY abandons the access with no error pulse; after release the FSM is in IDLE.

Verification
REQ-039 Byte load: read, mode=000, addr=0x1003, busReady after 2 BUSY cycles with busRData=0x80FF_FF12 -> busAddr=0x1000, busByteEn=1000, stall high for 3 cycles, memReadData=0xFFFF_FF80 in DONE.
REQ-040 Half store: write, mode=001, addr=0x2002, data=0x0000_ABCD -> busByteEn=1100, busWData=0xABCD_ABCD, busWrite=1 until busReady.
REQ-041 Misaligned word read: addr=0x3001 -> accErr pulses for 1 cycle, busValid stays 0, stall=0.
REQ-042 Timeout: TIMEOUT=4, busReady held low -> busValid high for 4 cycles then low, accErr pulses, memReadData=0, then DONE and IDLE.
REQ-043 Unsigned half load: mode=101, addr=0x0, busRData=0x1234_8001 -> memReadData=0x0000_8001.
REQ-044 Reset mid-access: rst_n pulsed low during BUSY -> all outputs 0 immediately; the next legal request is accepted normally.
